// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one single-port memory: the data port has priority,
// a starvation counter guarantees fetch progress, and one access is tracked at a time.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  state_t     state, state_nx;
  logic [2:0] lat_cnt, lat_cnt_nx;
  logic       owner_d, owner_d_nx;
  logic       owner_we, owner_we_nx;
  logic [3:0] starve_cnt, starve_cnt_nx;
  logic       done;
  logic       slot;
  logic       favor_if;
  logic       grant_d;
  logic       grant_if;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      owner_d    <= 1'b0;
      owner_we   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      lat_cnt    <= lat_cnt_nx;
      owner_d    <= owner_d_nx;
      owner_we   <= owner_we_nx;
      starve_cnt <= starve_cnt_nx;
    end
  end

  // Grants are gated by nRESET so the memory side goes quiet the instant reset asserts.
  always_comb begin
    state_nx      = state;
    lat_cnt_nx    = lat_cnt;
    owner_d_nx    = owner_d;
    owner_we_nx   = owner_we;
    starve_cnt_nx = starve_cnt;
    if_gnt        = 1'b0;
    d_gnt         = 1'b0;
    mem_en        = 1'b0;
    mem_rw        = 1'b1;
    mem_addr      = '0;
    mem_wdata     = '0;

    done     = (state == BUSY) && (lat_cnt == LAT_LAST);
    slot     = nRESET && ((state == IDLE) || done);
    favor_if = if_req && (starve_cnt == STARVE_MAX);
    grant_d  = slot && d_req && !favor_if;
    grant_if = slot && if_req && !grant_d;

    if (grant_d) begin
      d_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_rw    = ~d_we;
      mem_addr  = d_addr;
      mem_wdata = d_we ? d_wdata : '0;
    end else if (grant_if) begin
      if_gnt   = 1'b1;
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end

    if (grant_d || grant_if) begin
      state_nx    = BUSY;
      lat_cnt_nx  = 3'd1;
      owner_d_nx  = grant_d;
      owner_we_nx = grant_d && d_we;
    end else if (done) begin
      state_nx   = IDLE;
      lat_cnt_nx = '0;
    end else if (state == BUSY) begin
      lat_cnt_nx = lat_cnt + 3'd1;
    end

    if (!if_req || grant_if)
      starve_cnt_nx = '0;
    else if (starve_cnt != STARVE_MAX)
      starve_cnt_nx = starve_cnt + 4'd1;
  end

  // Response is registered one cycle after the completion cycle and steered to the owner.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= done && !owner_d;
      d_rvalid  <= done && owner_d;
      if (done && !owner_d)
        if_rdata <= mem_rdata;
      if (done && owner_d)
        d_rdata <= owner_we ? '0 : mem_rdata;
    end
  end

endmodule
